// File: rtl/ctrl_unit_pkg.sv
// Shared encodings for the Lab B multi-cycle controller: FSM states, opcodes,
// and ALU function selects (must match the alu block).
package ctrl_unit_pkg;

    typedef enum logic [2:0] {
        ST_INIT   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_LOAD_A = 3'd3,
        ST_LOAD_B = 3'd4,
        ST_STORE  = 3'd5,
        ST_ALU_OP = 3'd6,
        ST_HALT   = 3'd7
    } state_e;

    localparam logic [3:0] OP_NOOP  = 4'h0;
    localparam logic [3:0] OP_LOAD  = 4'h1;
    localparam logic [3:0] OP_STORE = 4'h2;
    localparam logic [3:0] OP_ADD   = 4'h3;
    localparam logic [3:0] OP_SUB   = 4'h4;
    localparam logic [3:0] OP_XOR   = 4'h5;
    localparam logic [3:0] OP_OR    = 4'h6;
    localparam logic [3:0] OP_AND   = 4'h7;
    localparam logic [3:0] OP_INC   = 4'h8;
    localparam logic [3:0] OP_MOV   = 4'h9;
    localparam logic [3:0] OP_HALT  = 4'hF;

    localparam logic [2:0] ALU_NONE = 3'b000;
    localparam logic [2:0] ALU_ADD  = 3'b001;
    localparam logic [2:0] ALU_SUB  = 3'b010;
    localparam logic [2:0] ALU_MOV  = 3'b011;
    localparam logic [2:0] ALU_XOR  = 3'b100;
    localparam logic [2:0] ALU_OR   = 3'b101;
    localparam logic [2:0] ALU_AND  = 3'b110;
    localparam logic [2:0] ALU_INC  = 3'b111;

    function automatic logic [2:0] alu_sel(input logic [3:0] op);
        case (op)
            OP_ADD:  return ALU_ADD;
            OP_SUB:  return ALU_SUB;
            OP_XOR:  return ALU_XOR;
            OP_OR:   return ALU_OR;
            OP_AND:  return ALU_AND;
            OP_INC:  return ALU_INC;
            OP_MOV:  return ALU_MOV;
            default: return ALU_NONE;
        endcase
    endfunction

    function automatic logic is_alu_op(input logic [3:0] op);
        return (op >= OP_ADD) && (op <= OP_MOV);
    endfunction

endpackage

// File: rtl/ctrl_unit_pc_counter.sv
// Program counter: increments on inc, wraps naturally at 2^PC_BITS, async clear.
module pc_counter #(
    parameter int unsigned PC_BITS = 7
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               inc,
    output logic [PC_BITS-1:0] pc
);

    logic [PC_BITS-1:0] pc_q, pc_d;

    always_comb begin
        pc_d = pc_q;
        if (inc) begin
            pc_d = pc_q + PC_BITS'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q <= '0;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc = pc_q;

endmodule

// File: rtl/ctrl_unit.sv
// Multi-cycle controller: fetches from a synchronous ROM, decodes, and drives
// Moore-style register-file / data-memory / ALU strobes from state and IR.
module ctrl_unit
    import ctrl_unit_pkg::*;
#(
    parameter int unsigned PC_BITS     = 7,
    parameter int unsigned D_ADDR_BITS = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [15:0]            instr,
    output logic [PC_BITS-1:0]     pc_addr,
    output logic                   im_rd,
    output logic [D_ADDR_BITS-1:0] d_addr,
    output logic                   d_rd,
    output logic                   d_wr,
    output logic                   rf_s,
    output logic [3:0]             rf_w_addr,
    output logic                   rf_w_wr,
    output logic [3:0]             rf_ra_addr,
    output logic [3:0]             rf_rb_addr,
    output logic [2:0]             alu_s0,
    output logic [2:0]             state_out,
    output logic                   halted
);

    state_e      state_q, state_d;
    logic [15:0] ir_q, ir_d;
    logic        pc_inc;

    pc_counter #(.PC_BITS(PC_BITS)) u_pc (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (pc_inc),
        .pc    (pc_addr)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_INIT;
            ir_q    <= '0;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
        end
    end

    // Next state in DECODE comes from the ROM word directly, since IR only
    // captures it on the same edge.
    always_comb begin
        state_d    = state_q;
        ir_d       = ir_q;
        pc_inc     = 1'b0;
        im_rd      = 1'b0;
        d_addr     = '0;
        d_rd       = 1'b0;
        d_wr       = 1'b0;
        rf_s       = 1'b0;
        rf_w_addr  = '0;
        rf_w_wr    = 1'b0;
        rf_ra_addr = '0;
        rf_rb_addr = '0;
        alu_s0     = ALU_NONE;
        halted     = 1'b0;
        case (state_q)
            ST_INIT: state_d = ST_FETCH;
            ST_FETCH: begin
                im_rd   = 1'b1;
                pc_inc  = 1'b1;
                state_d = ST_DECODE;
            end
            ST_DECODE: begin
                ir_d = instr;
                if (instr[15:12] == OP_LOAD)        state_d = ST_LOAD_A;
                else if (instr[15:12] == OP_STORE)  state_d = ST_STORE;
                else if (is_alu_op(instr[15:12]))   state_d = ST_ALU_OP;
                else if (instr[15:12] == OP_HALT)   state_d = ST_HALT;
                else                                state_d = ST_FETCH;
            end
            ST_LOAD_A: begin
                d_addr  = ir_q[D_ADDR_BITS-1:0];
                d_rd    = 1'b1;
                state_d = ST_LOAD_B;
            end
            ST_LOAD_B: begin
                d_addr    = ir_q[D_ADDR_BITS-1:0];
                d_rd      = 1'b1;
                rf_s      = 1'b1;
                rf_w_addr = ir_q[11:8];
                rf_w_wr   = 1'b1;
                state_d   = ST_FETCH;
            end
            ST_STORE: begin
                d_addr     = ir_q[D_ADDR_BITS-1:0];
                rf_ra_addr = ir_q[11:8];
                d_wr       = 1'b1;
                state_d    = ST_FETCH;
            end
            ST_ALU_OP: begin
                rf_ra_addr = ir_q[7:4];
                rf_rb_addr = ir_q[3:0];
                alu_s0     = alu_sel(ir_q[15:12]);
                rf_w_addr  = ir_q[11:8];
                rf_w_wr    = 1'b1;
                state_d    = ST_FETCH;
            end
            ST_HALT: halted = 1'b1;
            default: state_d = ST_INIT;
        endcase
    end

    assign state_out = 3'(state_q);

endmodule

// File: tb/tb_ctrl_unit.sv
// Self-checking bench for ctrl_unit: directed + random programs against an
// instruction-level expected-trace model; a PC_BITS=3 instance checks PC wrap.
module tb_ctrl_unit;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, rst3_n;
    logic [15:0] instr, instr3;

    logic [6:0]  pc_addr;
    logic        im_rd, d_rd, d_wr, rf_s, rf_w_wr, halted;
    logic [7:0]  d_addr;
    logic [3:0]  rf_w_addr, rf_ra_addr, rf_rb_addr;
    logic [2:0]  alu_s0, state_out;

    logic [2:0]  pc3;
    logic        im_rd3, d_rd3, d_wr3, rf_s3, rf_w_wr3, halted3;
    logic [7:0]  d_addr3;
    logic [3:0]  rf_w_addr3, rf_ra_addr3, rf_rb_addr3;
    logic [2:0]  alu3, state3;

    ctrl_unit #(.PC_BITS(7), .D_ADDR_BITS(8)) dut (
        .clk(clk), .rst_n(rst_n), .instr(instr), .pc_addr(pc_addr), .im_rd(im_rd),
        .d_addr(d_addr), .d_rd(d_rd), .d_wr(d_wr), .rf_s(rf_s), .rf_w_addr(rf_w_addr),
        .rf_w_wr(rf_w_wr), .rf_ra_addr(rf_ra_addr), .rf_rb_addr(rf_rb_addr),
        .alu_s0(alu_s0), .state_out(state_out), .halted(halted)
    );

    ctrl_unit #(.PC_BITS(3), .D_ADDR_BITS(8)) dut3 (
        .clk(clk), .rst_n(rst3_n), .instr(instr3), .pc_addr(pc3), .im_rd(im_rd3),
        .d_addr(d_addr3), .d_rd(d_rd3), .d_wr(d_wr3), .rf_s(rf_s3), .rf_w_addr(rf_w_addr3),
        .rf_w_wr(rf_w_wr3), .rf_ra_addr(rf_ra_addr3), .rf_rb_addr(rf_rb_addr3),
        .alu_s0(alu3), .state_out(state3), .halted(halted3)
    );

    logic [15:0] mem [0:127];

    // Synchronous ROMs: word valid the cycle after the read strobe.
    always @(posedge clk) if (im_rd)  instr  <= mem[pc_addr];
    always @(posedge clk) if (im_rd3) instr3 <= 16'h0000;

    typedef struct packed {
        logic [2:0] st;
        logic [6:0] pc;
        logic [5:0] strb;   // {im_rd, d_rd, d_wr, rf_s, rf_w_wr, halted}
        logic [7:0] da;
        logic [3:0] wa;
        logic [3:0] ra;
        logic [3:0] rb;
        logic [2:0] alu;
    } exp_t;

    int   checks;
    int   failures;
    exp_t q[$];

    function automatic exp_t rec(input logic [2:0] st, input logic [6:0] pc);
        exp_t r;
        r    = '0;
        r.st = st;
        r.pc = pc;
        return r;
    endfunction

    function automatic logic [2:0] alu_code(input logic [3:0] op);
        case (op)
            4'h3: return 3'b001;
            4'h4: return 3'b010;
            4'h5: return 3'b100;
            4'h6: return 3'b101;
            4'h7: return 3'b110;
            4'h8: return 3'b111;
            4'h9: return 3'b011;
            default: return 3'b000;
        endcase
    endfunction

    // Expected per-cycle trace of one instruction, from the instruction rules.
    task automatic plan(input logic [15:0] w, inout logic [6:0] pc);
        exp_t       r;
        logic [3:0] op;
        op = w[15:12];
        r = rec(3'd1, pc); r.strb = 6'b100000; q.push_back(r);
        pc = pc + 7'd1;
        q.push_back(rec(3'd2, pc));
        if (op == 4'h1) begin
            r = rec(3'd3, pc); r.da = w[7:0]; r.strb = 6'b010000; q.push_back(r);
            r = rec(3'd4, pc); r.da = w[7:0]; r.strb = 6'b010110; r.wa = w[11:8];
            q.push_back(r);
        end else if (op == 4'h2) begin
            r = rec(3'd5, pc); r.da = w[7:0]; r.ra = w[11:8]; r.strb = 6'b001000;
            q.push_back(r);
        end else if (op >= 4'h3 && op <= 4'h9) begin
            r = rec(3'd6, pc); r.ra = w[7:4]; r.rb = w[3:0]; r.wa = w[11:8];
            r.alu = alu_code(op); r.strb = 6'b000010; q.push_back(r);
        end else if (op == 4'hF) begin
            for (int i = 0; i < 20; i++) begin
                r = rec(3'd7, pc); r.strb = 6'b000001; q.push_back(r);
            end
        end
    endtask

    task automatic check_now(input exp_t e, input string tag);
        checks++;
        assert (state_out === e.st) else begin
            failures++; $error("FAIL %s state got=%0d want=%0d", tag, state_out, e.st);
        end
        checks++;
        assert (pc_addr === e.pc) else begin
            failures++; $error("FAIL %s pc_addr got=%0d want=%0d", tag, pc_addr, e.pc);
        end
        checks++;
        assert ({im_rd, d_rd, d_wr, rf_s, rf_w_wr, halted} === e.strb) else begin
            failures++; $error("FAIL %s strobes got=%b want=%b", tag,
                               {im_rd, d_rd, d_wr, rf_s, rf_w_wr, halted}, e.strb);
        end
        checks++;
        assert ({d_addr, rf_w_addr, rf_ra_addr, rf_rb_addr} === {e.da, e.wa, e.ra, e.rb}) else begin
            failures++; $error("FAIL %s addrs got=%h want=%h", tag,
                               {d_addr, rf_w_addr, rf_ra_addr, rf_rb_addr}, {e.da, e.wa, e.ra, e.rb});
        end
        checks++;
        assert (alu_s0 === e.alu) else begin
            failures++; $error("FAIL %s alu_s0 got=%b want=%b", tag, alu_s0, e.alu);
        end
    endtask

    task automatic drain(input string tag);
        int k;
        k = 0;
        while (q.size() > 0) begin
            check_now(q.pop_front(), $sformatf("%s[%0d]", tag, k));
            k++;
            @(negedge clk);
        end
    endtask

    initial begin
        logic [6:0]  pc;
        logic [15:0] w;
        logic [2:0]  e3;
        checks = 0; failures = 0;
        rst_n = 1'b0; rst3_n = 1'b0; instr = '0; instr3 = '0;

        for (int i = 0; i < 128; i++) mem[i] = 16'h0000;
        mem[0] = 16'h1305; mem[1] = 16'h3123; mem[2] = 16'h2480;
        mem[3] = 16'h4567; mem[4] = 16'h5567; mem[5] = 16'h6567;
        mem[6] = 16'h7567; mem[7] = 16'h8567; mem[8] = 16'h9567;
        mem[9] = 16'hA000;
        for (int i = 10; i < 60; i++) begin
            w = 16'($urandom);
            if (w[15:12] == 4'hF) w[15:12] = 4'hE;
            mem[i] = w;
        end
        mem[60] = 16'hF000;

        repeat (2) @(negedge clk);
        check_now(rec(3'd0, 7'd0), "reset");

        // Whole program through HALT, then 20 halted cycles.
        rst_n = 1'b1;
        pc = 7'd0;
        q.push_back(rec(3'd0, 7'd0));
        for (int i = 0; i <= 60; i++) plan(mem[i], pc);
        drain("prog");

        // Reset mid-LOAD_B must clear outputs without a clock edge.
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        q.delete();
        pc = 7'd0;
        q.push_back(rec(3'd0, 7'd0));
        plan(mem[0], pc);
        for (int k = 0; k < 5; k++) begin
            check_now(q.pop_front(), $sformatf("pre_rst[%0d]", k));
            if (k < 4) @(negedge clk);
        end
        rst_n = 1'b0;
        #1;
        check_now(rec(3'd0, 7'd0), "async_rst");
        @(negedge clk);
        rst_n = 1'b1;
        q.delete();
        pc = 7'd0;
        q.push_back(rec(3'd0, 7'd0));
        plan(mem[0], pc);
        plan(mem[1], pc);
        drain("after_rst");

        // PC_BITS=3 instance running NOOPs: each PC value held 2 cycles, wraps 7->0.
        rst3_n = 1'b1;
        for (int k = 0; k < 20; k++) begin
            e3 = 3'((k / 2) % 8);
            checks++;
            assert (pc3 === e3) else begin
                failures++; $error("FAIL wrap3[%0d] pc_addr got=%0d want=%0d", k, pc3, e3);
            end
            checks++;
            assert ({d_rd3, d_wr3, rf_w_wr3, halted3} === 4'b0000) else begin
                failures++; $error("FAIL wrap3[%0d] strobes got=%b want=0000", k,
                                   {d_rd3, d_wr3, rf_w_wr3, halted3});
            end
            @(negedge clk);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
